cp0_regfile: RTL and testbench

- Coprocessor-0 register file: the responder for the EX stage's CP0 access port (cp0we/cp0Addr/cp0wData in, cp0rData out).
- Holds Count, Compare, Status, Cause, EPC and PRId.
- Generates the timer interrupt pending bit, and records exception entry and eret on the excptype code issued by EX.
- Feeds cause/status back to EX and epc to the PC-redirect logic.

---
 rtl/cp0_regfile.sv | 116 +++++++++++
 tb/tb_cp0_regfile.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file holding Count, Compare, Status, Cause, EPC and PRId.
// It also raises the timer interrupt and records exception entry and eret.
module cp0_regfile #(
    parameter logic [31:0] PRID       = 32'h0000_0001,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cp0we,
    input  logic [4:0]  cp0Addr,
    input  logic [31:0] cp0wData,
    output logic [31:0] cp0rData,
    input  logic [31:0] excptype,
    input  logic [31:0] pc,
    input  logic [4:0]  intIn,
    output logic [31:0] cause,
    output logic [31:0] status,
    output logic [31:0] epc,
    output logic        timerInt
);
    localparam logic [4:0] AddrCount   = 5'd9;
    localparam logic [4:0] AddrCompare = 5'd11;
    localparam logic [4:0] AddrStatus  = 5'd12;
    localparam logic [4:0] AddrCause   = 5'd13;
    localparam logic [4:0] AddrEpc     = 5'd14;
    localparam logic [4:0] AddrPrid    = 5'd15;

    localparam logic [31:0] ExcTimer   = 32'h0000_0004;
    localparam logic [31:0] ExcSyscall = 32'h0000_0100;
    localparam logic [31:0] ExcEret    = 32'h0000_0200;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        exc_take;
    logic        eret_take;

    always_comb begin
        exc_take  = (excptype == ExcTimer) || (excptype == ExcSyscall);
        eret_take = (excptype == ExcEret);

        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        status_d  = status_q;
        cause_d   = cause_q;
        epc_d     = epc_q;

        if (cp0we && (cp0Addr == AddrCount)) begin
            count_d = cp0wData;
        end

        // Match uses the pre-increment Count; a Compare write overrides it.
        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            cause_d[10] = 1'b1;
        end
        if (cp0we && (cp0Addr == AddrCompare)) begin
            compare_d   = cp0wData;
            cause_d[10] = 1'b0;
        end

        cause_d[15:11] = intIn;

        if (exc_take) begin
            epc_d        = pc;
            status_d[1]  = 1'b1;
            cause_d[6:2] = (excptype == ExcSyscall) ? 5'h08 : 5'h00;
            cause_d[31]  = 1'b0;
        end else if (eret_take) begin
            status_d[1] = 1'b0;
        end else if (cp0we) begin
            case (cp0Addr)
                AddrStatus: status_d    = cp0wData;
                AddrCause:  cause_d[9:8] = cp0wData[9:8];
                AddrEpc:    epc_d       = cp0wData;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            status_q  <= STATUS_RST;
            cause_q   <= 32'd0;
            epc_q     <= 32'd0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        cp0rData = 32'd0;
        case (cp0Addr)
            AddrCount:   cp0rData = count_q;
            AddrCompare: cp0rData = compare_q;
            AddrStatus:  cp0rData = status_q;
            AddrCause:   cp0rData = cause_q;
            AddrEpc:     cp0rData = epc_q;
            AddrPrid:    cp0rData = PRID;
            default:     cp0rData = 32'd0;
        endcase
    end

    assign cause    = cause_q;
    assign status   = status_q;
    assign epc      = epc_q;
    assign timerInt = cause_q[10];

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: field-level model checked every cycle plus directed literal checks.
module tb_cp0_regfile;
    localparam logic [31:0] PRID       = 32'h0000_0001;
    localparam logic [31:0] STATUS_RST = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        cp0we;
    logic [4:0]  cp0Addr;
    logic [31:0] cp0wData;
    logic [31:0] cp0rData;
    logic [31:0] excptype;
    logic [31:0] pc;
    logic [4:0]  intIn;
    logic [31:0] cause;
    logic [31:0] status;
    logic [31:0] epc;
    logic        timerInt;

    int checks   = 0;
    int failures = 0;

    cp0_regfile #(
        .PRID       (PRID),
        .STATUS_RST (STATUS_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cp0we    (cp0we),
        .cp0Addr  (cp0Addr),
        .cp0wData (cp0wData),
        .cp0rData (cp0rData),
        .excptype (excptype),
        .pc       (pc),
        .intIn    (intIn),
        .cause    (cause),
        .status   (status),
        .epc      (epc),
        .timerInt (timerInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model kept as architectural fields rather than packed registers.
    logic        m_valid = 1'b0;
    logic [31:0] m_count, m_compare, m_status, m_epc;
    logic        m_timer;
    logic [4:0]  m_int;
    logic [1:0]  m_ip;
    logic [4:0]  m_exccode;

    function automatic logic wr(input logic [4:0] a);
        return cp0we && (cp0Addr == a);
    endfunction

    function automatic logic [31:0] m_cause();
        return {16'd0, m_int, m_timer, m_ip, 1'b0, m_exccode, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    wire is_exc  = (excptype == 32'h4) || (excptype == 32'h100);
    wire is_eret = (excptype == 32'h200);
    wire is_trap = is_exc || is_eret;

    always @(posedge clk) begin
        if (rst) begin
            m_valid   <= 1'b1;
            m_count   <= 32'd0;
            m_compare <= 32'd0;
            m_status  <= STATUS_RST;
            m_epc     <= 32'd0;
            m_timer   <= 1'b0;
            m_int     <= 5'd0;
            m_ip      <= 2'd0;
            m_exccode <= 5'd0;
        end else begin
            m_count   <= wr(5'd9) ? cp0wData : m_count + 32'd1;
            m_compare <= wr(5'd11) ? cp0wData : m_compare;
            m_timer   <= wr(5'd11) ? 1'b0
                       : (m_timer || (m_compare != 0 && m_count == m_compare));
            m_int     <= intIn;
            m_ip      <= (!is_trap && wr(5'd13)) ? cp0wData[9:8] : m_ip;
            m_exccode <= (excptype == 32'h100) ? 5'h08
                       : (excptype == 32'h4) ? 5'h00 : m_exccode;
            m_status  <= is_exc ? (m_status | 32'h2)
                       : is_eret ? (m_status & ~32'h2)
                       : wr(5'd12) ? cp0wData : m_status;
            m_epc     <= is_exc ? pc : (!is_eret && wr(5'd14)) ? cp0wData : m_epc;
        end
    end

    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            chk("model_cause", cause, m_cause());
            chk("model_status", status, m_status);
            chk("model_epc", epc, m_epc);
            chk("model_timerInt", {31'd0, timerInt}, {31'd0, m_timer});
            chk("model_rdata", cp0rData, m_read(cp0Addr));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; cp0we = 1'b0; cp0Addr = 5'd9; cp0wData = 32'd0;
        excptype = 32'd0; pc = 32'd0; intIn = 5'd0;
        cyc(); cyc();
        chk("rst_count", cp0rData, 32'd0);
        chk("rst_status", status, STATUS_RST);
        chk("rst_cause", cause, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_timerInt", {31'd0, timerInt}, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("count_after_rst", cp0rData, i);
        end

        // Timer
        repeat (7) cyc();
        chk("count_10", cp0rData, 32'd10);
        cp0we = 1'b1; cp0Addr = 5'd11; cp0wData = 32'd20;
        cyc();
        cp0we = 1'b0; cp0Addr = 5'd9;
        repeat (9) cyc();
        chk("count_20", cp0rData, 32'd20);
        chk("timer_before", {31'd0, timerInt}, 32'd0);
        cyc();
        chk("timer_set", {31'd0, timerInt}, 32'd1);
        chk("cause10_set", {31'd0, cause[10]}, 32'd1);
        repeat (3) cyc();
        chk("timer_sticky", {31'd0, timerInt}, 32'd1);
        cp0we = 1'b1; cp0Addr = 5'd11; cp0wData = 32'd100;
        cyc();
        cp0we = 1'b0;
        chk("timer_clear", {31'd0, cause[10]}, 32'd0);

        // Syscall with colliding EPC write, then eret
        pc = 32'h40; excptype = 32'h100;
        cp0we = 1'b1; cp0Addr = 5'd14; cp0wData = 32'hDEAD;
        cyc();
        cp0we = 1'b0;
        chk("sys_epc", epc, 32'h40);
        chk("sys_exl", {31'd0, status[1]}, 32'd1);
        chk("sys_exccode", {27'd0, cause[6:2]}, 32'd8);
        excptype = 32'h200;
        cyc();
        excptype = 32'h0;
        chk("eret_exl", {31'd0, status[1]}, 32'd0);
        chk("eret_epc", epc, 32'h40);

        // Read path
        cp0Addr = 5'd15; #1;
        chk("read_prid", cp0rData, PRID);
        cp0Addr = 5'd3; #1;
        chk("read_unmapped", cp0rData, 32'd0);
        cp0we = 1'b1; cp0Addr = 5'd12; cp0wData = 32'h0000_0401; #1;
        chk("read_old_status", cp0rData, 32'd0);
        cyc();
        cp0we = 1'b0; #1;
        chk("read_new_status", cp0rData, 32'h0000_0401);

        // Timer exception sets EXL, then reset discards it
        pc = 32'h80; excptype = 32'h4;
        cyc();
        excptype = 32'h0;
        chk("tint_status", status, 32'h0000_0403);
        chk("tint_epc", epc, 32'h80);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_status", status, STATUS_RST);
        chk("rst2_epc", epc, 32'd0);

        // Cause masking and interrupt sampling
        cp0we = 1'b1; cp0Addr = 5'd13; cp0wData = 32'hFFFF_FFFF;
        cyc();
        cp0we = 1'b0;
        chk("cause_mask", cause, 32'h0000_0300);
        intIn = 5'b10101;
        cyc();
        chk("cause_int", cause, 32'h0000_AB00);
        intIn = 5'd0;

        // Count wrap
        cp0we = 1'b1; cp0Addr = 5'd9; cp0wData = 32'hFFFF_FFFE;
        cyc();
        cp0we = 1'b0;
        chk("wrap_fe", cp0rData, 32'hFFFF_FFFE);
        cyc();
        chk("wrap_ff", cp0rData, 32'hFFFF_FFFF);
        cyc();
        chk("wrap_0", cp0rData, 32'd0);

        // Compare write colliding with a match
        cp0we = 1'b1; cp0Addr = 5'd11; cp0wData = 32'd5;
        cyc();
        cp0we = 1'b0; cp0Addr = 5'd9;
        repeat (4) cyc();
        chk("coll_count", cp0rData, 32'd5);
        cp0we = 1'b1; cp0Addr = 5'd11; cp0wData = 32'd5;
        cyc();
        cp0we = 1'b0;
        chk("coll_timer", {31'd0, timerInt}, 32'd0);
        repeat (2) cyc();
        chk("coll_timer_later", {31'd0, timerInt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
